// File: rtl/log2_core_if.sv
// rtl/log2_core_if.sv - operand/result bundle between the log2 core and its neighbours
interface log2_core_if #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7
);
    logic                   valid_log_i;
    logic                   sgn_i;
    logic [EXP_WIDTH-1:0]   exp_i;
    logic [FRACT_WIDTH-1:0] fract_i;
    logic                   ready_o;
    logic                   valid_log_o;
    logic [EXP_WIDTH-1:0]   integer_o;
    logic [FRACT_WIDTH-1:0] log_f_o;
    logic [1:0]             exc_o;

    modport master (
        output valid_log_i, sgn_i, exp_i, fract_i,
        input  ready_o, valid_log_o, integer_o, log_f_o, exc_o
    );

    modport slave (
        input  valid_log_i, sgn_i, exp_i, fract_i,
        output ready_o, valid_log_o, integer_o, log_f_o, exc_o
    );
endinterface

// File: rtl/log2_core.sv
// rtl/log2_core.sv - iterative bfloat16 log2 core, square-and-compare fraction, one bit per clock
// Optional round-half-up guard step enabled by defining LOG_ROUND_EN.
module log2_core #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7,
    parameter int BIAS        = 127,
    parameter int SQ_FRAC     = 16
) (
    input  logic       clk,
    input  logic       rst,
    log2_core_if.slave bus
);
`ifdef LOG_ROUND_EN
    localparam int N = FRACT_WIDTH + 1;
`else
    localparam int N = FRACT_WIDTH;
`endif
    localparam int KW = $clog2(N + 1);
    localparam int YW = SQ_FRAC + 1;
    localparam int PW = 2 * YW;
    localparam logic [EXP_WIDTH-1:0] BIAS_V = BIAS[EXP_WIDTH-1:0];

    typedef enum logic {S_IDLE, S_SQUARE} state_t;

    state_t                 r_state;
    logic [KW-1:0]          r_k;
    logic [YW-1:0]          r_y;
    logic [N-1:0]           r_sr;
    logic [EXP_WIDTH-1:0]   r_int_cap;
    logic [1:0]             r_exc_cap;
    logic                   r_ready;
    logic                   r_valid;
    logic [EXP_WIDTH-1:0]   r_int;
    logic [FRACT_WIDTH-1:0] r_logf;
    logic [1:0]             r_exc;

    logic [1:0]             w_exc;
    logic [YW-1:0]          w_y_load;
    logic [PW-1:0]          w_prod;
    logic [SQ_FRAC+1:0]     w_p;
    logic                   w_bit;
    logic [YW-1:0]          w_y_next;
    logic [N-1:0]           w_sr_next;
    logic [FRACT_WIDTH-1:0] w_logf;
    logic                   w_last;

    always_comb begin
        w_exc = 2'b00;
        if ((&bus.exp_i) && (bus.fract_i != '0))
            w_exc = 2'b11;
        else if (bus.sgn_i && (bus.exp_i != '0))
            w_exc = 2'b11;
        else if (&bus.exp_i)
            w_exc = 2'b10;
        else if (bus.exp_i == '0)
            w_exc = 2'b01;
    end

    assign w_y_load  = YW'({1'b1, bus.fract_i}) << (SQ_FRAC - FRACT_WIDTH);

    // Q1.SQ_FRAC squared gives Q2.(2*SQ_FRAC); keep the top bits as Q2.SQ_FRAC.
    assign w_prod    = {{YW{1'b0}}, r_y} * {{YW{1'b0}}, r_y};
    assign w_p       = w_prod[2*SQ_FRAC+1:SQ_FRAC];
    assign w_bit     = w_p[SQ_FRAC+1];
    assign w_y_next  = w_bit ? w_p[SQ_FRAC+1:1] : w_p[SQ_FRAC:0];
    assign w_sr_next = {r_sr[N-2:0], w_bit};
    assign w_last    = (r_k == KW'(N - 1));

`ifdef LOG_ROUND_EN
    logic [FRACT_WIDTH-1:0] w_trunc;
    assign w_trunc = w_sr_next[N-1:1];
    // Saturate instead of carrying into the integer part.
    assign w_logf  = (&w_trunc) ? w_trunc : w_trunc + FRACT_WIDTH'(w_sr_next[0]);
`else
    assign w_logf  = w_sr_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_y       <= '0;
            r_sr      <= '0;
            r_int_cap <= '0;
            r_exc_cap <= 2'b00;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_int     <= '0;
            r_logf    <= '0;
            r_exc     <= 2'b00;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_log_i) begin
                        r_int_cap <= bus.exp_i - BIAS_V;
                        r_y       <= w_y_load;
                        r_k       <= '0;
                        r_sr      <= '0;
                        r_exc_cap <= w_exc;
                        r_ready   <= 1'b0;
                        r_state   <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    r_y  <= w_y_next;
                    r_sr <= w_sr_next;
                    r_k  <= r_k + KW'(1);
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_valid <= 1'b1;
                        r_exc   <= r_exc_cap;
                        r_int   <= (r_exc_cap == 2'b00) ? r_int_cap : '0;
                        r_logf  <= (r_exc_cap == 2'b00) ? w_logf : '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o     = r_ready;
    assign bus.valid_log_o = r_valid;
    assign bus.integer_o   = r_int;
    assign bus.log_f_o     = r_logf;
    assign bus.exc_o       = r_exc;
endmodule

// File: tb/tb_log2_core.sv
// tb/tb_log2_core.sv - directed self-checking bench for log2_core
module tb_log2_core;
`ifdef LOG_ROUND_EN
    localparam int N = 8;
    localparam logic [6:0] LF_1P5 = 7'h4B;
`else
    localparam int N = 7;
    localparam logic [6:0] LF_1P5 = 7'h4A;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    log2_core_if #(.EXP_WIDTH(8), .FRACT_WIDTH(7)) bus ();

    log2_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic [7:0]  int_e;
        logic [6:0]  lf_e;
        logic [1:0]  exc_e;
    } vec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [15:0] v);
        bus.sgn_i       = v[15];
        bus.exp_i       = v[14:7];
        bus.fract_i     = v[6:0];
        bus.valid_log_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_log_i = 1'b0;
    endtask

    // Returns the number of edges from the accept edge to the edge after which the strobe is seen.
    task automatic wait_strobe(output int lat);
        lat = 0;
        while (!bus.valid_log_o && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op(input logic [15:0] v, output int lat);
        drive(v);
        wait_strobe(lat);
    endtask

    vec_t vecs[7];
    int   lat;
    int   strobes;

    initial begin
        vecs[0] = '{16'h3FC0, 8'h00, LF_1P5, 2'b00};
        vecs[1] = '{16'h3F40, 8'hFF, LF_1P5, 2'b00};
        vecs[2] = '{16'h4000, 8'h01, 7'h00, 2'b00};
        vecs[3] = '{16'h0000, 8'h00, 7'h00, 2'b01};
        vecs[4] = '{16'h7F80, 8'h00, 7'h00, 2'b10};
        vecs[5] = '{16'h7FC1, 8'h00, 7'h00, 2'b11};
        vecs[6] = '{16'hBF80, 8'h00, 7'h00, 2'b11};

        bus.valid_log_i = 1'b0;
        bus.sgn_i       = 1'b0;
        bus.exp_i       = '0;
        bus.fract_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_log_o), 32'd0);
        chk("rst_int", 32'(bus.integer_o), 32'h0);
        chk("rst_logf", 32'(bus.log_f_o), 32'h0);
        chk("rst_exc", 32'(bus.exc_o), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        op(16'h3F80, lat);
        chk("one_lat", 32'(lat), 32'(N));
        chk("one_int", 32'(bus.integer_o), 32'h00);
        chk("one_logf", 32'(bus.log_f_o), 32'h00);
        chk("one_exc", 32'(bus.exc_o), 32'h0);
        chk("one_ready_strobe", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        chk("one_pulse_end", 32'(bus.valid_log_o), 32'd0);

        foreach (vecs[i]) begin
            op(vecs[i].v, lat);
            chk($sformatf("v%04h_lat", vecs[i].v), 32'(lat), 32'(N));
            chk($sformatf("v%04h_int", vecs[i].v), 32'(bus.integer_o), 32'(vecs[i].int_e));
            chk($sformatf("v%04h_logf", vecs[i].v), 32'(bus.log_f_o), 32'(vecs[i].lf_e));
            chk($sformatf("v%04h_exc", vecs[i].v), 32'(bus.exc_o), 32'(vecs[i].exc_e));
            @(posedge clk); #1;
        end

        // Busy: a second operand three cycles into SQUARE must be dropped.
        drive(16'h3F80);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("busy_ready_low", 32'(bus.ready_o), 32'd0);
        drive(16'h3FC0);
        wait_strobe(lat);
        chk("busy_lat", 32'(lat + 4), 32'(N));
        chk("busy_int", 32'(bus.integer_o), 32'h00);
        chk("busy_logf", 32'(bus.log_f_o), 32'h00);
        op(16'h4000, lat);
        chk("b2b_lat", 32'(lat), 32'(N));
        chk("b2b_int", 32'(bus.integer_o), 32'h01);
        chk("b2b_logf", 32'(bus.log_f_o), 32'h00);
        strobes = 0;
        repeat (2 * N + 2) begin
            @(posedge clk); #1;
            if (bus.valid_log_o) strobes++;
        end
        chk("busy_no_extra_strobe", 32'(strobes), 32'd0);

        // Reset two cycles into SQUARE.
        drive(16'h3FC0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.ready_o), 32'd1);
        chk("mid_rst_valid", 32'(bus.valid_log_o), 32'd0);
        chk("mid_rst_int", 32'(bus.integer_o), 32'h0);
        chk("mid_rst_logf", 32'(bus.log_f_o), 32'h0);
        chk("mid_rst_exc", 32'(bus.exc_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        strobes = 0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (bus.valid_log_o) strobes++;
        end
        chk("mid_rst_no_strobe", 32'(strobes), 32'd0);
        op(16'h3F80, lat);
        chk("post_rst_lat", 32'(lat), 32'(N));
        chk("post_rst_int", 32'(bus.integer_o), 32'h00);
        chk("post_rst_logf", 32'(bus.log_f_o), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
